// File: rtl/cpu_axi_bridge_pkg.sv
// ============================================================================
// Module : cpu_axi_bridge_pkg
// Desc   : Shared AXI id, transfer size and FSM state encodings for the bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_axi_bridge_pkg;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_B    = 2'd2
  } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_wstrb_gen.sv
// ============================================================================
// Module : axi_wstrb_gen
// Desc   : Byte-lane strobe generation from transfer size and address offset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_wstrb_gen
  import cpu_axi_bridge_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] offset,
  output logic [3:0] wstrb
);

  always_comb begin
    wstrb = 4'b1111;
    case (size)
      SIZE_BYTE: wstrb = 4'b0001 << offset;
      SIZE_HALF: wstrb = 4'b0011 << offset;
      default:   wstrb = 4'b1111;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_axi_bridge.sv
// ============================================================================
// Module : cpu_axi_bridge
// Desc   : Inst/data sram-like interfaces to one AXI3 master, one read and one
//          write outstanding, data reads prioritised over fetch.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  rd_state_t r_rstate, w_rnext;
  wr_state_t r_wstate, w_wnext;

  logic              w_rd_data_acc, w_rd_inst_acc, w_wr_acc;
  logic              w_rd_holds_data, w_r_hs, w_aw_fin, w_w_fin;
  logic [3:0]        w_strb;

  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arsize;
  logic [3:0]        r_rid;
  logic [ADDR_W-1:0] r_awaddr;
  logic [2:0]        r_awsize;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_aw_done, r_w_done;

  // Acceptance is gated by resetn so no addr_ok escapes while held in reset.
  assign w_rd_data_acc   = resetn && (r_rstate == R_IDLE) && data_req && !data_wr
                           && (r_wstate == W_IDLE);
  assign w_rd_inst_acc   = resetn && (r_rstate == R_IDLE) && inst_req && !w_rd_data_acc;
  // A store must not overtake a load still in flight on the read side.
  assign w_rd_holds_data = (r_rstate != R_IDLE) && (r_rid == ID_DATA);
  assign w_wr_acc        = resetn && (r_wstate == W_IDLE) && data_req && data_wr
                           && !w_rd_holds_data;

  assign w_r_hs   = (r_rstate == R_R) && rvalid && (rid == r_rid);
  assign w_aw_fin = r_aw_done || awready;
  assign w_w_fin  = r_w_done || wready;

  axi_wstrb_gen u_wstrb_gen (
    .size   (data_size),
    .offset (data_addr[1:0]),
    .wstrb  (w_strb)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
    end else begin
      r_rstate <= w_rnext;
      r_wstate <= w_wnext;
    end
  end

  always_comb begin
    w_rnext = r_rstate;
    arvalid = 1'b0;
    rready  = 1'b0;
    case (r_rstate)
      R_IDLE: if (w_rd_data_acc || w_rd_inst_acc) w_rnext = R_AR;
      R_AR: begin
        arvalid = 1'b1;
        if (arready) w_rnext = R_R;
      end
      R_R: begin
        rready = 1'b1;
        if (w_r_hs) w_rnext = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    w_wnext = r_wstate;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (r_wstate)
      W_IDLE: if (w_wr_acc) w_wnext = W_AW;
      W_AW: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        if (w_aw_fin && w_w_fin) w_wnext = W_B;
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_araddr <= '0;
      r_arsize <= '0;
      r_rid    <= '0;
    end else if (w_rd_data_acc) begin
      r_araddr <= data_addr;
      r_arsize <= {1'b0, data_size};
      r_rid    <= ID_DATA;
    end else if (w_rd_inst_acc) begin
      r_araddr <= inst_addr;
      r_arsize <= {1'b0, SIZE_WORD};
      r_rid    <= ID_INST;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_awaddr  <= '0;
      r_awsize  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_wr_acc) begin
      r_awaddr  <= data_addr;
      r_awsize  <= {1'b0, data_size};
      r_wdata   <= data_wdata;
      r_wstrb   <= w_strb;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_wstate == W_AW) begin
      if (awvalid && awready) r_aw_done <= 1'b1;
      if (wvalid && wready)   r_w_done  <= 1'b1;
    end
  end

  assign inst_addr_ok = w_rd_inst_acc;
  assign data_addr_ok = w_rd_data_acc || w_wr_acc;
  assign inst_data_ok = w_r_hs && (r_rid == ID_INST);
  assign data_data_ok = (w_r_hs && (r_rid == ID_DATA)) || ((r_wstate == W_B) && bvalid);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid   = r_rid;
  assign araddr = r_araddr;
  assign arsize = r_arsize;
  assign awaddr = r_awaddr;
  assign awsize = r_awsize;
  assign wdata  = r_wdata;
  assign wstrb  = r_wstrb;

endmodule

`default_nettype wire

// File: tb/tb_cpu_axi_bridge.sv
// ============================================================================
// Module : tb_cpu_axi_bridge
// Desc   : Directed vector bench for cpu_axi_bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] rd;
    int          ar_dly;
    int          r_dly;
    logic [3:0]  exp_id;
    logic [2:0]  exp_size;
  } rd_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wd;
    logic [3:0]  exp_strb;
    int          aw_dly;
    int          w_dly;
  } wr_vec_t;

  rd_vec_t rv[4];
  wr_vec_t wv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input rd_vec_t v);
    if (v.is_data) begin
      data_req = 1'b1; data_wr = 1'b0; data_size = v.size; data_addr = v.addr;
    end else begin
      inst_req = 1'b1; inst_addr = v.addr;
    end
    #1;
    chk("rd_addr_ok", v.is_data ? data_addr_ok : inst_addr_ok, 1);
    tick();
    inst_req = 1'b0; data_req = 1'b0;
    for (int c = 0; c <= v.ar_dly; c++) begin
      #1;
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, v.addr);
      chk("arid", arid, v.exp_id);
      chk("arsize", arsize, v.exp_size);
      arready = (c == v.ar_dly);
      tick();
    end
    arready = 1'b0;
    for (int c = 0; c <= v.r_dly; c++) begin
      #1;
      chk("rready", rready, 1);
      if (c == v.r_dly) begin
        rvalid = 1'b1; rid = v.exp_id; rdata = v.rd;
        #1;
        chk("inst_data_ok", inst_data_ok, !v.is_data);
        chk("data_data_ok", data_data_ok, v.is_data);
        chk("rd_rdata", v.is_data ? data_rdata : inst_rdata, v.rd);
      end else begin
        chk("early_ok", inst_data_ok | data_data_ok, 0);
      end
      tick();
    end
    rvalid = 1'b0;
    #1;
    chk("ok_pulse_end", inst_data_ok | data_data_ok, 0);
    chk("rready_idle", rready, 0);
  endtask

  task automatic do_write(input wr_vec_t v);
    int n;
    n = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    data_req = 1'b1; data_wr = 1'b1; data_size = v.size;
    data_addr = v.addr; data_wdata = v.wd;
    #1;
    chk("wr_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 1'b0; data_wr = 1'b0;
    for (int c = 0; c <= n; c++) begin
      #1;
      chk("awvalid", awvalid, (c <= v.aw_dly));
      chk("wvalid", wvalid, (c <= v.w_dly));
      if (c == 0) begin
        chk("awaddr", awaddr, v.addr);
        chk("awsize", awsize, {1'b0, v.size});
        chk("wdata", wdata, v.wd);
        chk("wstrb", wstrb, v.exp_strb);
      end
      awready = (c == v.aw_dly);
      wready  = (c == v.w_dly);
      tick();
    end
    awready = 1'b0; wready = 1'b0;
    #1;
    chk("bready", bready, 1);
    chk("aw_w_dropped", awvalid | wvalid, 0);
    chk("b_no_early_ok", data_data_ok, 0);
    bvalid = 1'b1;
    #1;
    chk("wr_data_ok", data_data_ok, 1);
    tick();
    bvalid = 1'b0;
    #1;
    chk("wr_ok_pulse_end", data_data_ok, 0);
    chk("bready_idle", bready, 0);
  endtask

  initial begin
    rv[0] = '{1'b0, 32'hBFC00000, 2'd2, 32'h3C010001, 3, 0, 4'd0, 3'd2};
    rv[1] = '{1'b1, 32'h80001000, 2'd2, 32'h12345678, 0, 2, 4'd1, 3'd2};
    rv[2] = '{1'b1, 32'h80001002, 2'd1, 32'hBEEF0000, 1, 0, 4'd1, 3'd1};
    rv[3] = '{1'b0, 32'hBFC00004, 2'd2, 32'h8C020004, 0, 1, 4'd0, 3'd2};

    wv[0] = '{32'h80000003, 2'd0, 32'hAB000000, 4'b1000, 0, 0};
    wv[1] = '{32'h80000010, 2'd2, 32'hDEADBEEF, 4'b1111, 2, 0};
    wv[2] = '{32'h80000006, 2'd1, 32'h55AA0000, 4'b1100, 0, 3};
    wv[3] = '{32'h80000001, 2'd0, 32'h00003400, 4'b0010, 1, 1};

    resetn = 1'b0;
    inst_req = 0; data_req = 0; data_wr = 0; data_size = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
    repeat (3) tick();
    chk("rst_valids", {28'd0, arvalid, rready, awvalid, wvalid}, 0);
    chk("rst_bready", bready, 0);
    chk("rst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    chk("rst_araddr", araddr, 0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) do_read(rv[i]);
    for (int i = 0; i < 4; i++) do_write(wv[i]);

    // Data load beats a simultaneous fetch; fetch follows afterwards.
    inst_req = 1; inst_addr = 32'hBFC00020;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h80001000;
    #1;
    chk("prio_data_ok", data_addr_ok, 1);
    chk("prio_inst_ok", inst_addr_ok, 0);
    tick();
    data_req = 0;
    #1;
    chk("prio_arid_data", arid, 1);
    chk("prio_inst_wait", inst_addr_ok, 0);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'hCAFEF00D;
    #1;
    chk("prio_ddok", data_data_ok, 1);
    chk("prio_inst_wait2", inst_addr_ok, 0);
    tick();
    rvalid = 0;
    #1;
    chk("prio_inst_acc", inst_addr_ok, 1);
    tick();
    inst_req = 0;
    #1;
    chk("prio_arid_inst", arid, 0);
    chk("prio_araddr_inst", araddr, 32'hBFC00020);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'h24020001;
    #1;
    chk("prio_idok", inst_data_ok, 1);
    tick();
    rvalid = 0;

    // Store waits in B; load blocked, fetch proceeds.
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h80000020;
    data_wdata = 32'h01020304;
    tick();
    data_req = 0; data_wr = 0;
    awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0;
    #1;
    chk("pend_bready", bready, 1);
    data_req = 1; data_wr = 0; data_addr = 32'h80000040;
    inst_req = 1; inst_addr = 32'hBFC00010;
    #1;
    chk("pend_ld_blocked", data_addr_ok, 0);
    chk("pend_inst_acc", inst_addr_ok, 1);
    tick();
    inst_req = 0;
    #1;
    chk("pend_arid", arid, 0);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'h11112222;
    #1;
    chk("pend_idok", inst_data_ok, 1);
    chk("pend_no_ddok", data_data_ok, 0);
    chk("pend_ld_blocked2", data_addr_ok, 0);
    tick();
    rvalid = 0;
    #1;
    chk("pend_ld_blocked3", data_addr_ok, 0);
    bvalid = 1;
    #1;
    chk("pend_wr_ok", data_data_ok, 1);
    chk("pend_ld_blocked4", data_addr_ok, 0);
    tick();
    bvalid = 0;
    #1;
    chk("pend_ld_acc", data_addr_ok, 1);
    tick();
    data_req = 0;
    #1;
    chk("pend_ld_arid", arid, 1);
    chk("pend_ld_araddr", araddr, 32'h80000040);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'h33334444;
    #1;
    chk("pend_ld_ddok", data_data_ok, 1);
    chk("pend_ld_rdata", data_rdata, 32'h33334444);
    tick();
    rvalid = 0;

    // Asynchronous reset while waiting in R_R.
    inst_req = 1; inst_addr = 32'hBFC00100;
    tick();
    inst_req = 0;
    arready = 1; tick(); arready = 0;
    #1;
    chk("rr_rready", rready, 1);
    inst_req = 1; rvalid = 1; rid = 4'd0; rdata = 32'h77777777;
    resetn = 0;
    #1;
    chk("arst_rready", rready, 0);
    chk("arst_arvalid", arvalid, 0);
    chk("arst_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    tick(); tick();
    rvalid = 0; inst_req = 0;
    resetn = 1;
    do_read(rv[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Sits directly downstream of the CPU core top level.
- Converts the core's instruction-side and data-side sram-like request/response interfaces into one AXI3 master port.
- Allows one outstanding read and one outstanding write.
- Data reads have priority over instruction fetch.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; strobe logic assumes 4 bytes)

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous reset, active low
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch address, word aligned
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data returned this cycle
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request valid
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  byte address
- data_wdata  in  32  store data, already lane-aligned
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data or store completion
- data_rdata  out  32  load data
- arid  out  4  0 = inst, 1 = data
- araddr  out  32  read address
- arsize  out  3  {1'b0, size}
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  read id
- rdata  in  32  read data
- rvalid  in  1  R valid
- rready  out  1  R ready
- awaddr  out  32  write address
- awsize  out  3  {1'b0, size}
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wdata  out  32  write data
- wstrb  out  4  byte strobes
- wvalid  out  1  W valid
- wready  in  1  W ready
- bvalid  in  1  B valid
- bready  out  1  B ready
- Fixed AXI fields (len = 0, burst = INCR, lock/cache/prot = 0, awid/wid = 1, wlast = 1) are constants tied off at the integration level.

Behaviour:
- Reset (resetn = 0, asynchronous): both FSMs idle; all valid, ready, addr_ok and data_ok outputs 0; captured registers 0.
- Read FSM states: R_IDLE -> R_AR -> R_R -> R_IDLE.
  - In R_IDLE, a read request is accepted (addr_ok = 1, combinational).
  - Data read is accepted if data_req & ~data_wr and the write FSM is W_IDLE.
  - Otherwise inst_req is accepted.
  - Data wins when both are eligible.
  - On accept: capture addr, size and id; next state R_AR.
- R_AR: arvalid = 1, fields stable until arready, then go to R_R.
- R_R: rready = 1.
  - On rvalid, pulse inst_data_ok or data_data_ok for one cycle according to the captured id.
  - Drive the matching rdata combinationally from the rdata input.
  - Return to R_IDLE.
  - Earliest acceptance of the next request is the following cycle.
- Write FSM states: W_IDLE -> W_AW -> W_B -> W_IDLE.
  - In W_IDLE, accept data_req & data_wr only when the read FSM is not holding a data read (its captured id != 1), so a store cannot overtake an earlier load. Instruction reads may proceed.
  - On accept: data_addr_ok = 1; capture address, size, wdata and strobe.
- W_AW: awvalid and wvalid both 1.
  - Track aw_done and w_done separately; each valid drops after its own handshake.
  - Handshakes may complete in the same cycle or in either order.
  - Go to W_B when both are done.
- W_B: bready = 1; on bvalid pulse data_data_ok and return to W_IDLE.
- Strobe from size and addr[1:0]:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- A data request is never given addr_ok on both the read and write paths in the same cycle.
- data_data_ok for a read and for a write never coincide: a data read is not accepted while a write is pending, and the reverse.
- Reset mid-transaction aborts all state immediately; no data_ok is produced for aborted requests.
- The core holds req and its fields stable until addr_ok; the bridge never relies on them after acceptance.

Decomposition:
- Shared header (mycpu.h): AXI id constants (ID_INST = 0, ID_DATA = 1), size encodings, FSM state encodings.
- Sub-module: axi_wstrb_gen, combinational size/offset -> wstrb, reused by future cache write paths.
- Read and write FSMs stay inline.

Test Plan:
- Inst fetch 0xBFC00000, arready delayed 3 cycles, rdata 0x3C010001 -> araddr = 0xBFC00000, arid = 0; inst_data_ok pulses one cycle with inst_rdata = 0x3C010001.
- inst_req and data load 0x80001000 in the same cycle -> data_addr_ok = 1, inst_addr_ok = 0; arid = 1 issued first; inst accepted after data_data_ok.
- Byte store 0xAB at addr 0x80000003 -> awsize = 0, wstrb = 4'b1000, wdata passed through; data_data_ok on bvalid.
- awready delayed 2 cycles after wready -> wvalid drops after its handshake, awvalid holds until awready; exactly one B wait and one data_data_ok.
- Store pending (bvalid withheld), then load request -> data_addr_ok stays 0 until the store's data_data_ok; inst fetch still completes meanwhile.
- resetn asserted during R_R -> arvalid, rready and all ok signals go to 0 asynchronously; after release, a new fetch completes normally.
